// File: rtl/systolic_tile_controller_pkg.sv
// ============================================================================
// Module   : systolic_pkg
// Purpose  : Shared state encoding and drain-depth helper for the tile controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4,
    ST_FLUSH  = 3'd5
  } state_t;

  // Skewed wavefront needs N-1 cycles to enter and N-1 cycles to exit the array.
  function automatic int drain_cycles(input int n);
    return 2 * (n - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_tile_controller_if.sv
// ============================================================================
// Module   : systolic_tile_controller_if
// Purpose  : Host/datapath handshake bundle of the systolic tile controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface systolic_tile_controller_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int MAX_K      = 64,
  parameter int CNT_WIDTH  = $clog2(MAX_K + 2 * ARRAY_SIZE),
  parameter int KLEN_WIDTH = $clog2(MAX_K + 1)
);

  logic                  start;
  logic [KLEN_WIDTH-1:0] k_len;
  logic                  accumulate;
  logic                  abort;
  logic                  in_valid;
  logic                  in_ready;
  logic                  result_valid;
  logic                  result_ready;
  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic                  cfg_err;
  logic                  pe_en;
  logic                  pe_clear_acc;
  logic                  skew_load_en;
  logic                  skew_flush;
  logic [CNT_WIDTH-1:0]  cycle_count;

  modport master (
    output start, k_len, accumulate, abort, in_valid, result_ready,
    input  in_ready, result_valid, busy, done, aborted, cfg_err,
           pe_en, pe_clear_acc, skew_load_en, skew_flush, cycle_count
  );

  modport slave (
    input  start, k_len, accumulate, abort, in_valid, result_ready,
    output in_ready, result_valid, busy, done, aborted, cfg_err,
           pe_en, pe_clear_acc, skew_load_en, skew_flush, cycle_count
  );

endinterface

`default_nettype wire

// File: rtl/systolic_perf_counter.sv
// ============================================================================
// Module   : systolic_perf_counter
// Purpose  : 32-bit saturating event counter with synchronous clear
//            (used only when SYSTOLIC_PERF_CNT_EN is defined).
// Revision : 1.0
// ============================================================================
`default_nettype none

module systolic_perf_counter (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        i_clr,
  input  wire logic        i_inc,
  output logic [31:0]      o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/systolic_tile_controller.sv
// ============================================================================
// Module   : systolic_tile_controller
// Purpose  : Tile sequencing FSM for the NxN systolic array with stall,
//            result handshake, accumulate chaining and abort.
//            Optional perf counters under macro SYSTOLIC_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module systolic_tile_controller
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int MAX_K      = 64,
  parameter int CNT_WIDTH  = $clog2(MAX_K + 2 * ARRAY_SIZE),
  parameter int KLEN_WIDTH = $clog2(MAX_K + 1)
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  systolic_tile_controller_if.slave ctrl
`ifdef SYSTOLIC_PERF_CNT_EN
  ,
  output logic [31:0]               o_perf_busy_cycles,
  output logic [31:0]               o_perf_stall_cycles
`endif
);

  localparam int DRAIN_CYCLES = drain_cycles(ARRAY_SIZE);
  localparam int DRAIN_LAST   = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [KLEN_WIDTH-1:0] r_klen_q, w_klen_nxt;
  logic                  r_cfg_err, w_cfg_err_nxt;
  logic                  w_beat, w_klen_ok, w_abort_act;
  logic                  w_start_try, w_start_acc;

  assign w_klen_ok   = (ctrl.k_len != '0) && (int'(ctrl.k_len) <= MAX_K);
  assign w_beat      = (r_state == ST_LOAD) && ctrl.in_valid;
  assign w_abort_act = ctrl.abort && ((r_state == ST_CLEAR) || (r_state == ST_LOAD) ||
                                      (r_state == ST_DRAIN) || (r_state == ST_RESULT));

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_start_try   = 1'b0;
    w_start_acc   = 1'b0;
    w_cfg_err_nxt = 1'b0;
    w_klen_nxt    = r_klen_q;
    case (r_state)
      ST_IDLE:  w_start_try = ctrl.start;
      ST_CLEAR: begin
        w_state_nxt = ST_LOAD;
        w_cnt_nxt   = '0;
      end
      ST_LOAD: begin
        if (w_beat) begin
          if ((r_cnt + CNT_WIDTH'(1)) == CNT_WIDTH'(r_klen_q)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (DRAIN_CYCLES == 0) ? ST_RESULT : ST_DRAIN;
          end else begin
            w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (r_cnt == CNT_WIDTH'(DRAIN_LAST)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RESULT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      ST_RESULT: begin
        if (ctrl.result_ready) begin
          w_state_nxt = ST_IDLE;
          w_start_try = ctrl.start;
        end
      end
      ST_FLUSH: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase

    // Abort outranks everything, including a start riding on the result handshake.
    if (w_abort_act) begin
      w_state_nxt = ST_FLUSH;
      w_cnt_nxt   = '0;
      w_start_try = 1'b0;
    end

    w_start_acc   = w_start_try && w_klen_ok;
    w_cfg_err_nxt = w_start_try && !w_klen_ok;
    if (w_start_acc) begin
      w_state_nxt = ctrl.accumulate ? ST_LOAD : ST_CLEAR;
      w_cnt_nxt   = '0;
      w_klen_nxt  = ctrl.k_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_klen_q  <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_klen_q  <= w_klen_nxt;
      r_cfg_err <= w_cfg_err_nxt;
    end
  end

  assign ctrl.in_ready     = (r_state == ST_LOAD);
  assign ctrl.result_valid = (r_state == ST_RESULT);
  assign ctrl.busy         = (r_state != ST_IDLE);
  assign ctrl.done         = (r_state == ST_RESULT) && ctrl.result_ready && !ctrl.abort;
  assign ctrl.aborted      = (r_state == ST_FLUSH);
  assign ctrl.cfg_err      = r_cfg_err;
  assign ctrl.pe_en        = w_beat || (r_state == ST_DRAIN);
  assign ctrl.pe_clear_acc = (r_state == ST_CLEAR) || (r_state == ST_FLUSH);
  assign ctrl.skew_load_en = w_beat;
  assign ctrl.skew_flush   = (r_state == ST_CLEAR) || (r_state == ST_FLUSH);
  assign ctrl.cycle_count  = ((r_state == ST_LOAD) || (r_state == ST_DRAIN)) ? r_cnt : '0;

`ifdef SYSTOLIC_PERF_CNT_EN
  systolic_perf_counter u_perf_busy (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_start_acc),
    .i_inc   (r_state != ST_IDLE),
    .o_count (o_perf_busy_cycles)
  );

  systolic_perf_counter u_perf_stall (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_start_acc),
    .i_inc   ((r_state == ST_LOAD) && !ctrl.in_valid),
    .o_count (o_perf_stall_cycles)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_tile_controller.sv
// ============================================================================
// Module   : tb_systolic_tile_controller
// Purpose  : Directed + randomized bench for systolic_tile_controller against
//            a phase/beat-counting reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_systolic_tile_controller;

  localparam int N  = 4;
  localparam int MK = 64;
  localparam int KW = $clog2(MK + 1);
  localparam int CW = $clog2(MK + 2 * N);

  localparam int PH_IDLE = 0, PH_CLR = 1, PH_LD = 2, PH_DR = 3, PH_RS = 4, PH_FL = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_tile_controller_if #(.ARRAY_SIZE(N), .MAX_K(MK)) bus ();

`ifdef SYSTOLIC_PERF_CNT_EN
  logic [31:0] perf_busy, perf_stall;
`endif

  systolic_tile_controller #(.ARRAY_SIZE(N), .MAX_K(MK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
`ifdef SYSTOLIC_PERF_CNT_EN
    ,
    .o_perf_busy_cycles  (perf_busy),
    .o_perf_stall_cycles (perf_stall)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase plus beats taken / drain cycles elapsed.
  int  m_ph, m_beat, m_drn, m_klen;
  bit  m_cfg;
  longint m_pbusy, m_pstall;

  int  cyc, first_done, n_cfg_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_beat = 0; m_drn = 0; m_klen = 0; m_cfg = 0;
    m_pbusy = 0; m_pstall = 0;
  endtask

  task automatic compare_outputs();
    check("in_ready",     bus.in_ready,     m_ph == PH_LD);
    check("result_valid", bus.result_valid, m_ph == PH_RS);
    check("busy",         bus.busy,         m_ph != PH_IDLE);
    check("done",         bus.done,         (m_ph == PH_RS) && bus.result_ready && !bus.abort);
    check("aborted",      bus.aborted,      m_ph == PH_FL);
    check("cfg_err",      bus.cfg_err,      m_cfg);
    check("pe_en",        bus.pe_en,        ((m_ph == PH_LD) && bus.in_valid) || (m_ph == PH_DR));
    check("pe_clear_acc", bus.pe_clear_acc, (m_ph == PH_CLR) || (m_ph == PH_FL));
    check("skew_load_en", bus.skew_load_en, (m_ph == PH_LD) && bus.in_valid);
    check("skew_flush",   bus.skew_flush,   (m_ph == PH_CLR) || (m_ph == PH_FL));
    check("cycle_count",  32'(bus.cycle_count),
          (m_ph == PH_LD) ? m_beat : ((m_ph == PH_DR) ? m_drn : 0));
`ifdef SYSTOLIC_PERF_CNT_EN
    check("perf_busy",  perf_busy,  32'(m_pbusy));
    check("perf_stall", perf_stall, 32'(m_pstall));
`endif
    if (bus.done && first_done < 0) first_done = cyc;
    if (bus.cfg_err) n_cfg_seen++;
  endtask

  task automatic model_step();
    bit try_s, legal, acc;
    int nph;
    try_s = 0;
    nph   = m_ph;
    legal = (int'(bus.k_len) >= 1) && (int'(bus.k_len) <= MK);
    if (bus.abort && (m_ph == PH_CLR || m_ph == PH_LD || m_ph == PH_DR || m_ph == PH_RS)) begin
      nph = PH_FL;
    end else begin
      case (m_ph)
        PH_IDLE: try_s = bus.start;
        PH_CLR:  nph = PH_LD;
        PH_LD:   if (bus.in_valid) begin
                   m_beat++;
                   if (m_beat == m_klen) nph = (N == 1) ? PH_RS : PH_DR;
                 end
        PH_DR:   begin
                   m_drn++;
                   if (m_drn == 2 * (N - 1)) nph = PH_RS;
                 end
        PH_RS:   if (bus.result_ready) begin
                   nph = PH_IDLE;
                   try_s = bus.start;
                 end
        default: nph = PH_IDLE;
      endcase
    end
    acc = try_s && legal;
    if (acc) begin
      nph = bus.accumulate ? PH_LD : PH_CLR;
      m_klen = int'(bus.k_len);
    end
    if (acc) begin
      m_pbusy = 0; m_pstall = 0;
    end else begin
      if (m_ph != PH_IDLE) m_pbusy++;
      if (m_ph == PH_LD && !bus.in_valid) m_pstall++;
    end
    m_cfg = try_s && !legal;
    if (nph == PH_LD && m_ph != PH_LD) m_beat = 0;
    if (nph == PH_DR && m_ph != PH_DR) m_drn = 0;
    m_ph = nph;
  endtask

  task automatic tick(input bit st, input int k, input bit acc, input bit ab,
                      input bit iv, input bit rr);
    @(negedge clk);
    bus.start = st; bus.k_len = KW'(k); bus.accumulate = acc;
    bus.abort = ab; bus.in_valid = iv; bus.result_ready = rr;
    #1;
    compare_outputs();
    @(posedge clk);
    model_step();
    cyc++;
  endtask

  task automatic run_until(input int ph, input bit rr, input int budget);
    int n;
    n = 0;
    while (m_ph != ph && n < budget) begin
      tick(0, 0, 0, 0, 1, rr);
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  bus.busy, 0);
    check({tag, "_inrdy"}, bus.in_ready, 0);
    check({tag, "_pe_en"}, bus.pe_en, 0);
    check({tag, "_skew"},  bus.skew_load_en, 0);
    check({tag, "_cnt"},   32'(bus.cycle_count), 0);
    check({tag, "_rv"},    bus.result_valid, 0);
    check({tag, "_cfg"},   bus.cfg_err, 0);
  endtask

  int r, rk;

  initial begin
    bus.start = 0; bus.k_len = '0; bus.accumulate = 0;
    bus.abort = 0; bus.in_valid = 0; bus.result_ready = 0;
    model_reset();
    cyc = 0; first_done = -1; n_cfg_seen = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal clear tile, N=4, k_len=4
    cyc = 0; first_done = -1;
    tick(1, 4, 0, 0, 1, 1);
    repeat (13) tick(0, 0, 0, 0, 1, 1);
    check("nom_done_cycle", first_done, 12);

    // Stall two beats
    cyc = 0; first_done = -1;
    tick(1, 4, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    repeat (11) tick(0, 0, 0, 0, 1, 1);
    check("stall_done_cycle", first_done, 14);

    // Accumulate back-to-back
    tick(1, 8, 0, 0, 1, 0);
    run_until(PH_RS, 0, 40);
    cyc = 0; first_done = -1;
    tick(1, 8, 1, 0, 1, 1);
    cyc = 0; first_done = -1;
    repeat (16) tick(0, 0, 0, 0, 1, 1);
    check("acc_done_cycle", first_done, 14);

    // Config errors, then max depth
    n_cfg_seen = 0;
    tick(1, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 1, 1);
    tick(1, MK + 1, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 1, 1);
    check("cfg_err_pulses", n_cfg_seen, 2);
    tick(1, MK, 0, 0, 1, 1);
    run_until(PH_IDLE, 1, 100);

    // Abort in DRAIN at drain index 2
    cyc = 0; first_done = -1;
    tick(1, 4, 0, 0, 1, 1);
    repeat (7) tick(0, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 1, 1);
    tick(0, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 1, 1);
    check("abort_drain_no_done", first_done, -1);

    // Abort together with result handshake
    first_done = -1;
    tick(1, 3, 1, 0, 1, 0);
    run_until(PH_RS, 0, 40);
    tick(0, 0, 0, 1, 1, 1);
    tick(0, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 1, 1);
    check("abort_result_no_done", first_done, -1);

    // Asynchronous reset mid-LOAD
    tick(1, 8, 1, 0, 1, 1);
    tick(0, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 1, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1, 3, 0, 0, 1, 1);
    run_until(PH_IDLE, 1, 40);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      rk = 0;
      else if (r < 16) rk = MK + 1;
      else if (r < 19) rk = MK;
      else             rk = $urandom_range(1, 8);
      tick(($urandom_range(0, 99) < 40), rk, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 75),
           ($urandom_range(0, 99) < 50));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/systolic_tile_controller.md
Name: systolic_tile_controller

Overview:
- Next-generation FSM controller for the NxN systolic array. Supports a runtime reduction depth (k_len beats instead of a fixed N) and an accumulate mode that chains K-tiles without clearing PE accumulators.
- Adds an operand-stream valid/ready stall handshake, a result valid/ready handshake, back-to-back starts and abort.
- Sits between the host/DMA sequencer and the array datapath (PEs plus skew controller).

Parameters:
- ARRAY_SIZE, 4, array dimension N (>=1).
- MAX_K, 64, maximum reduction depth (beats per tile).
- CNT_WIDTH, $clog2(MAX_K+2*ARRAY_SIZE), width of internal counter and cycle_count.
- KLEN_WIDTH, $clog2(MAX_K+1), width of the k_len input.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a tile; sampled in IDLE, or in RESULT on the handshake cycle
- k_len  in  KLEN_WIDTH  beats for this tile; latched on an accepted start
- accumulate  in  1  1 = keep PE accumulators (skip CLEAR); latched on an accepted start
- abort  in  1  cancel the current tile
- in_valid  in  1  operand beat available
- in_ready  out  1  controller accepts a beat (= state==LOAD)
- result_valid  out  1  array results stable (= state==RESULT)
- result_ready  in  1  consumer has taken results
- busy  out  1  state != IDLE
- done  out  1  = result_valid & result_ready & !abort
- aborted  out  1  = state==FLUSH
- cfg_err  out  1  registered 1-cycle pulse: start rejected (k_len==0 or k_len>MAX_K)
- pe_en  out  1  = (LOAD & in_valid) | DRAIN
- pe_clear_acc  out  1  = CLEAR | FLUSH
- skew_load_en  out  1  = LOAD & in_valid
- skew_flush  out  1  = CLEAR | FLUSH
- cycle_count  out  CNT_WIDTH  beat index in LOAD; drain index in DRAIN; 0 otherwise

Behaviour:
- Reset: state IDLE; counter, k_len_q, acc_q and cfg_err are 0. All outputs are therefore 0.
- States: IDLE, CLEAR, LOAD, DRAIN, RESULT, FLUSH. DRAIN_CYCLES = 2*(ARRAY_SIZE-1).
- Start acceptance:
  - A start accepted with a legal k_len moves to CLEAR if accumulate=0, or directly to LOAD if accumulate=1.
  - An illegal k_len leaves state unchanged and pulses cfg_err on the next cycle.
- CLEAR: one cycle, then LOAD. Counter is 0.
- LOAD:
  - Counter increments only on an accepted beat (in_valid & in_ready).
  - With in_valid=0 the array is frozen: pe_en=0, skew_load_en=0, counter holds.
  - An accepted beat with counter==k_len_q-1 sets counter to 0 and moves to DRAIN. If DRAIN_CYCLES==0 (N=1) it moves straight to RESULT.
- DRAIN: counter increments every cycle. When counter==DRAIN_CYCLES-1 it moves to RESULT and counter returns to 0.
- RESULT:
  - result_valid held until result_ready.
  - On the handshake cycle done=1. Next state is IDLE; if start is also high with a legal k_len, next state is CLEAR or LOAD per accumulate (back-to-back).
  - An illegal start on the handshake cycle goes to IDLE and pulses cfg_err.
- Abort:
  - abort high in CLEAR, LOAD, DRAIN or RESULT moves to FLUSH next cycle, overriding every other transition including a result handshake (done suppressed).
  - FLUSH lasts one cycle (skew_flush=1, pe_clear_acc=1, aborted=1), then IDLE.
  - abort is ignored in IDLE and FLUSH.
- Latency (no stalls, result_ready=1): clear tile = 1 + k_len + 2(N-1) cycles from start-accept to the RESULT cycle; accumulate tile = k_len + 2(N-1).
- start is ignored while in CLEAR, LOAD, DRAIN and FLUSH.

Optional Feature:
- Macro: SYSTOLIC_PERF_CNT_EN.
- When defined, two extra outputs are present:
  - perf_busy_cycles[31:0]: counts cycles with busy=1.
  - perf_stall_cycles[31:0]: counts LOAD cycles with in_valid=0.
  - Both saturate at all-ones and clear on reset and on each accepted start.
- When undefined, neither port nor logic exists and behaviour is otherwise identical.

Decomposition:
- Package systolic_pkg holds:
  - the state_t enum (3-bit: IDLE, CLEAR, LOAD, DRAIN, RESULT, FLUSH);
  - the function drain_cycles(N) = 2*(N-1).
- One sub-module, systolic_perf_counter (saturating 32-bit counter with clear/inc), instantiated twice under SYSTOLIC_PERF_CNT_EN.

Test Plan:
- Nominal, N=4, k_len=4, accumulate=0, in_valid=1, result_ready=1, start at cycle 0: CLEAR in cycle 1; LOAD in cycles 2-5 with cycle_count 0..3; DRAIN in cycles 6-11; done=1 in cycle 12; IDLE in cycle 13.
- Stall, N=4, k_len=4: in_valid low for cycles 3-4: pe_en=0 and cycle_count held there; DRAIN entered in cycle 8; done in cycle 14; perf_stall_cycles=2 when SYSTOLIC_PERF_CNT_EN is defined.
- Accumulate back-to-back, N=4, k_len=8, result_ready=1: start=1, accumulate=1 held during RESULT of the previous tile: next cycle is LOAD; pe_clear_acc never asserted; 8 beats then 6 drain cycles.
- Config error: k_len=0, then k_len=MAX_K+1: state stays IDLE, busy=0, cfg_err pulses once per start; k_len=MAX_K is accepted.
- Abort: abort in the DRAIN cycle with counter=2: FLUSH next cycle (aborted=1, skew_flush=1, pe_clear_acc=1), then IDLE; done never asserted. Abort with result_ready in RESULT: done=0, FLUSH.
- Reset mid-LOAD: rst_n low asynchronously: all outputs 0 immediately; after release the controller is in IDLE and accepts a new start.
